butterfly: RTL and testbench
============================

Name: butterfly

Overview:
- Single radix-2 NTT/INTT butterfly over Z_q, with q = 8380417 (2^23 - 2^13 + 1).
- Computes one butterfly per clock with a fixed 3-cycle latency.
- Supports Cooley-Tukey (forward) and Gentleman-Sande (inverse) modes.
- Sits in the NTT datapath between the coefficient memory read port and the write-back port.

Parameters:
- Q, 8380417, modulus; fixed value taken from the shared package, not overridable per instance.
- LATENCY, 3, pipeline depth in cycles; informational, must match the RTL.

Ports:
- clk_i  in  1  clock; all state is updated on the rising edge.
- rst_ni  in  1  reset; one clock, reset asynchronous, active-low.
- valid_i  in  1  input vector valid.
- a_i  in  24  first operand, range [0, 2^24).
- b_i  in  24  second operand, range [0, 2^24).
- twiddle_i  in  23  twiddle factor, must be < Q.
- sel_red_i  in  1  1 = reduce a_i and b_i mod Q before the butterfly; 0 = operands already < Q.
- sel_butterfly_i  in  1  0 = Cooley-Tukey; 1 = Gentleman-Sande.
- valid_o  out  1  output valid.
- a_o  out  23  first result, always < Q.
- b_o  out  23  second result, always < Q.

Behaviour:
- Reset:
  - rst_ni low clears every pipeline register immediately (asynchronously).
  - valid_o = 0, a_o = 0, b_o = 0 while reset is held.
  - Vectors in flight are discarded.
- Pipeline and timing:
  - Fully pipelined, no stall, no backpressure.
  - A vector sampled with valid_i = 1 at edge N appears on a_o/b_o with valid_o = 1 after edge N+3.
  - valid_i = 0 propagates as a bubble.
  - Data registers may load regardless of valid; outputs are only meaningful when valid_o = 1.
  - Mode bits are sampled together with the data and travel down the pipeline.
- Stage 1, input conditioning:
  - sel_red_i = 1: a' = a_i mod Q and b' = b_i mod Q, using up to two conditional subtractions of Q (2^24-1 < 3Q).
  - sel_red_i = 0: a' = a_i[22:0], b' = b_i[22:0]. The caller guarantees the values are < Q; out-of-range results are unspecified.
- Stage 2:
  - CT mode: p = b' * twiddle_i, a full 46-bit product.
  - GS mode: s = (a' + b') mod Q and d = (a' - b') mod Q, then p = d * twiddle_i.
- Stage 3:
  - p is reduced mod Q to t in [0, Q).
  - CT mode: a_o = (a' + t) mod Q, b_o = (a' - t) mod Q.
  - GS mode: a_o = s, b_o = t.
  - No INTT scaling (no division by 2 or n) is applied in this block.
- Arithmetic rules:
  - Every modular add/sub uses one extra bit and a single conditional correction (add or subtract Q).
  - Results are exact, canonical representatives in [0, Q).
  - The reduction may exploit 2^23 ≡ 2^13 - 1 (mod Q) or use Barrett; only exactness is specified.
- Boundary conditions:
  - a' = t gives b_o = 0.
  - a' < t wraps to Q - (t - a').
  - twiddle = 0 in CT mode gives a_o = b_o = a'.
  - Inputs equal to 2Q with sel_red_i = 1 reduce to 0.

Decomposition:
- Package ntt_pkg holds:
  - Q = 8380417, COEF_W = 23, IN_W = 24;
  - enum butterfly_mode_e {BF_CT = 0, BF_GS = 1};
  - the add/sub-mod-Q helper functions.
- Sub-module mod_mul_q: 23x23 multiply plus reduce mod Q, pipelined over stages 2-3 (latency 2), instantiated once.

Test Plan:
- CT basic: a=1, b=1, w=1, red=0, bf=0 -> a_o=2, b_o=0, valid_o 3 cycles after valid_i.
- CT wrap: a=0, b=1, w=1 -> a_o=1, b_o=8380416. Also a=0, b=8380416, w=8380416 -> a_o=1, b_o=8380416.
- GS mode:
  - a=5, b=3, w=2, bf=1 -> a_o=8, b_o=4.
  - a=3, b=5, w=1 -> a_o=8, b_o=8380415.
- Input reduction, red=1, bf=0, w=1:
  - a=8380418, b=16760834 -> a_o=1, b_o=1.
  - a=16777215, b=0 -> a_o=16381, b_o=16381.
- Throughput: 100 random back-to-back vectors with mixed modes and valid bubbles -> every output matches a software model, in order, one per cycle.
- Reset mid-stream: drop rst_ni while 3 vectors are in flight -> valid_o=0, a_o=b_o=0 immediately. After release, the first new vector emerges exactly 3 cycles later, with no stale outputs.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants, mode encoding and modular add/sub helpers for the NTT datapath.
package ntt_pkg;

  localparam int unsigned COEF_W  = 23;
  localparam int unsigned IN_W    = 24;
  localparam int unsigned LATENCY = 3;

  // Modulus 2^23 - 2^13 + 1; fits in COEF_W bits.
  localparam logic [COEF_W-1:0] Q = 23'd8380417;

  typedef enum logic {
    BF_CT = 1'b0,
    BF_GS = 1'b1
  } butterfly_mode_e;

  // (x + y) mod Q for x, y < Q: one extra bit, one conditional subtract.
  function automatic logic [COEF_W-1:0] add_mod(input logic [COEF_W-1:0] x,
                                                input logic [COEF_W-1:0] y);
    logic [COEF_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[COEF_W-1:0];
  endfunction

  // (x - y) mod Q for x, y < Q: a borrow in the extra bit triggers one add of Q.
  function automatic logic [COEF_W-1:0] sub_mod(input logic [COEF_W-1:0] x,
                                                input logic [COEF_W-1:0] y);
    logic [COEF_W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[COEF_W]) d = d + {1'b0, Q};
    return d[COEF_W-1:0];
  endfunction

  // x mod Q for any 24-bit x; 2^24 - 1 < 3Q so two conditional subtracts suffice.
  function automatic logic [COEF_W-1:0] reduce_in(input logic [IN_W-1:0] x);
    logic [IN_W-1:0] r;
    r = x;
    if (r >= {1'b0, Q}) r = r - {1'b0, Q};
    if (r >= {1'b0, Q}) r = r - {1'b0, Q};
    return r[COEF_W-1:0];
  endfunction

endpackage

// File: rtl/butterfly_if.sv
// Operand/result bundle between the coefficient memory ports and the butterfly.
//
// Handshake: valid-only, no ready. The master presents a vector with valid_i = 1
// for exactly the cycle it is sampled; the slave always accepts. Results return
// with valid_o = 1 a fixed LATENCY cycles later; a_o/b_o carry no meaning while
// valid_o = 0.
interface butterfly_if;

  logic                          valid_i;
  logic [ntt_pkg::IN_W-1:0]      a_i;
  logic [ntt_pkg::IN_W-1:0]      b_i;
  logic [ntt_pkg::COEF_W-1:0]    twiddle_i;
  logic                          sel_red_i;
  logic                          sel_butterfly_i;
  logic                          valid_o;
  logic [ntt_pkg::COEF_W-1:0]    a_o;
  logic [ntt_pkg::COEF_W-1:0]    b_o;

  modport master (
    output valid_i, a_i, b_i, twiddle_i, sel_red_i, sel_butterfly_i,
    input  valid_o, a_o, b_o
  );

  modport slave (
    input  valid_i, a_i, b_i, twiddle_i, sel_red_i, sel_butterfly_i,
    output valid_o, a_o, b_o
  );

endinterface

// File: rtl/mod_mul_q.sv
// 23x23 modular multiplier: registered full product, then folded reduction mod Q.
// Latency 2: operands presented before edge K give t_o valid after edge K+1.
module mod_mul_q
  import ntt_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [COEF_W-1:0] x_i,
  input  logic [COEF_W-1:0] w_i,
  output logic [COEF_W-1:0] t_o
);

  localparam int unsigned P_W = 2 * COEF_W;

  logic [P_W-1:0]    prod_q;
  logic [COEF_W-1:0] t_q;
  logic [COEF_W-1:0] t_d;

  // Folding terms: each pass rewrites hi*2^23 + lo as hi*2^13 - hi + lo.
  logic [COEF_W-1:0] hi1, lo1, lo2, lo3;
  logic [13:0]       hi2;
  logic [4:0]        hi3;
  logic [36:0]       f1;
  logic [27:0]       f2;
  logic [23:0]       f3;
  logic [23:0]       f4;

  // Product register; the full 46-bit result is kept for exact reduction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prod_q <= '0;
    else         prod_q <= P_W'(x_i) * P_W'(w_i);
  end

  // Three folds bring the product below 2Q, one conditional subtract finishes.
  always_comb begin
    hi1 = prod_q[P_W-1:COEF_W];
    lo1 = prod_q[COEF_W-1:0];
    f1  = 37'({hi1, 13'd0}) + 37'(lo1) - 37'(hi1);
    hi2 = f1[36:COEF_W];
    lo2 = f1[COEF_W-1:0];
    f2  = 28'({hi2, 13'd0}) + 28'(lo2) - 28'(hi2);
    hi3 = f2[27:COEF_W];
    lo3 = f2[COEF_W-1:0];
    f3  = 24'({hi3, 13'd0}) + 24'(lo3) - 24'(hi3);
    f4  = (f3 >= {1'b0, Q}) ? (f3 - {1'b0, Q}) : f3;
    t_d = f4[COEF_W-1:0];
  end

  // Reduced product register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) t_q <= '0;
    else         t_q <= t_d;
  end

  assign t_o = t_q;

endmodule

// File: rtl/butterfly.sv
// Radix-2 NTT/INTT butterfly over Z_q, one vector per clock, LATENCY = 3.
// Pipeline: input-conditioning reg -> product reg -> reduced-product reg -> output reg.
module butterfly
  import ntt_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  butterfly_if.slave bf
);

  // Stage 1: conditioned operands
  logic              v1_q;
  butterfly_mode_e   m1_q;
  logic [COEF_W-1:0] a1_q, b1_q, w1_q;
  logic [COEF_W-1:0] a_cond, b_cond;

  // Stage 2: alongside the product register
  logic              v2_q;
  butterfly_mode_e   m2_q;
  logic [COEF_W-1:0] a2_q, s2_q;
  logic [COEF_W-1:0] mul_x;

  // Stage 3: alongside the reduced product
  logic              v3_q;
  butterfly_mode_e   m3_q;
  logic [COEF_W-1:0] a3_q, s3_q;
  logic [COEF_W-1:0] t;

  // Output stage
  logic              vo_q;
  logic [COEF_W-1:0] ao_q, bo_q;
  logic [COEF_W-1:0] ao_d, bo_d;

  // Optional mod-Q reduction of raw 24-bit operands.
  always_comb begin
    a_cond = bf.sel_red_i ? reduce_in(bf.a_i) : bf.a_i[COEF_W-1:0];
    b_cond = bf.sel_red_i ? reduce_in(bf.b_i) : bf.b_i[COEF_W-1:0];
  end

  // Stage 1 register: sample conditioned operands with their mode bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q <= 1'b0;
      m1_q <= BF_CT;
      a1_q <= '0;
      b1_q <= '0;
      w1_q <= '0;
    end else begin
      v1_q <= bf.valid_i;
      m1_q <= butterfly_mode_e'(bf.sel_butterfly_i);
      a1_q <= a_cond;
      b1_q <= b_cond;
      w1_q <= bf.twiddle_i;
    end
  end

  // CT multiplies b' by the twiddle; GS multiplies the difference a' - b'.
  always_comb begin
    mul_x = (m1_q == BF_GS) ? sub_mod(a1_q, b1_q) : b1_q;
  end

  mod_mul_q u_mul (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .x_i    (mul_x),
    .w_i    (w1_q),
    .t_o    (t)
  );

  // Stage 2 register: carry a' and the GS sum beside the product.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v2_q <= 1'b0;
      m2_q <= BF_CT;
      a2_q <= '0;
      s2_q <= '0;
    end else begin
      v2_q <= v1_q;
      m2_q <= m1_q;
      a2_q <= a1_q;
      s2_q <= add_mod(a1_q, b1_q);
    end
  end

  // Stage 3 register: keep side data aligned with the reduced product t.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v3_q <= 1'b0;
      m3_q <= BF_CT;
      a3_q <= '0;
      s3_q <= '0;
    end else begin
      v3_q <= v2_q;
      m3_q <= m2_q;
      a3_q <= a2_q;
      s3_q <= s2_q;
    end
  end

  // Final combine: CT gives (a' + t, a' - t); GS gives (s, t).
  always_comb begin
    ao_d = (m3_q == BF_GS) ? s3_q : add_mod(a3_q, t);
    bo_d = (m3_q == BF_GS) ? t    : sub_mod(a3_q, t);
  end

  // Output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vo_q <= 1'b0;
      ao_q <= '0;
      bo_q <= '0;
    end else begin
      vo_q <= v3_q;
      ao_q <= ao_d;
      bo_q <= bo_d;
    end
  end

  assign bf.valid_o = vo_q;
  assign bf.a_o     = ao_q;
  assign bf.b_o     = bo_q;

endmodule

// File: tb/tb_butterfly.sv
// Bench for the butterfly: directed literal vectors, random mixed-mode stream
// with bubbles, and an asynchronous reset while vectors are in flight.
module tb_butterfly;

  localparam int          LAT   = 3;
  localparam longint      QM    = 8380417;
  localparam logic [23:0] Q24   = 24'd8380417;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  // Expected per-capture entries: {valid, a_o, b_o}.
  logic [46:0] exp_q[$];

  butterfly_if bf_if ();

  butterfly dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bf     (bf_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [45:0] model(input logic [23:0] a, input logic [23:0] b,
                                        input logic [22:0] w, input logic red,
                                        input logic gs);
    longint ap, bp, t, s, d, ao, bo;
    ap = red ? (longint'(a) % QM) : longint'(a[22:0]);
    bp = red ? (longint'(b) % QM) : longint'(b[22:0]);
    if (!gs) begin
      t  = (bp * longint'(w)) % QM;
      ao = (ap + t) % QM;
      bo = (ap + QM - t) % QM;
    end else begin
      s  = (ap + bp) % QM;
      d  = (ap + QM - bp) % QM;
      t  = (d * longint'(w)) % QM;
      ao = s;
      bo = t;
    end
    return {ao[22:0], bo[22:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  initial begin : compare
    logic [46:0] e;
    logic [45:0] m;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        m = model(bf_if.a_i, bf_if.b_i, bf_if.twiddle_i, bf_if.sel_red_i,
                  bf_if.sel_butterfly_i);
        exp_q.push_back({bf_if.valid_i, m});
      end
      #1;
      if (!rst_n) begin
        chk("reset_valid_o", 64'(bf_if.valid_o), 64'(0));
        chk("reset_a_o", 64'(bf_if.a_o), 64'(0));
        chk("reset_b_o", 64'(bf_if.b_o), 64'(0));
      end else if (exp_q.size() <= LAT) begin
        chk("fill_valid_o", 64'(bf_if.valid_o), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("stream_valid_o", 64'(bf_if.valid_o), 64'(e[46]));
        if (e[46]) begin
          chk("stream_a_o", 64'(bf_if.a_o), 64'(e[45:23]));
          chk("stream_b_o", 64'(bf_if.b_o), 64'(e[22:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [23:0] a, input logic [23:0] b,
                       input logic [22:0] w, input logic red, input logic gs);
    bf_if.valid_i         = v;
    bf_if.a_i             = a;
    bf_if.b_i             = b;
    bf_if.twiddle_i       = w;
    bf_if.sel_red_i       = red;
    bf_if.sel_butterfly_i = gs;
  endtask

  function automatic logic [23:0] pick_operand(input logic red);
    logic [23:0] v;
    if (red) begin
      case ($urandom_range(0, 5))
        0:       v = 24'd16760834;
        1:       v = 24'hFFFFFF;
        2:       v = Q24;
        3:       v = Q24 - 24'd1;
        default: v = 24'($urandom_range(0, 16777215));
      endcase
    end else begin
      case ($urandom_range(0, 4))
        0:       v = 24'd0;
        1:       v = Q24 - 24'd1;
        default: v = 24'($urandom_range(0, 8380416));
      endcase
    end
    return v;
  endfunction

  function automatic logic [22:0] pick_twiddle();
    logic [22:0] w;
    case ($urandom_range(0, 5))
      0:       w = 23'd0;
      1:       w = 23'd1;
      2:       w = 23'd8380416;
      default: w = 23'($urandom_range(0, 8380416));
    endcase
    return w;
  endfunction

  task automatic drive_random(input logic force_valid);
    logic red;
    red = 1'($urandom_range(0, 1));
    drive(force_valid | ($urandom_range(0, 3) != 0), pick_operand(red), pick_operand(red),
          pick_twiddle(), red, 1'($urandom_range(0, 1)));
  endtask

  // One vector, then bubbles; check the literal result LAT edges after capture.
  task automatic run_directed(input string name, input logic [23:0] a, input logic [23:0] b,
                              input logic [22:0] w, input logic red, input logic gs,
                              input logic [22:0] ea, input logic [22:0] eb);
    @(negedge clk);
    drive(1'b1, a, b, w, red, gs);
    @(posedge clk);
    @(negedge clk);
    bf_if.valid_i = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    chk({name, "_valid_o"}, 64'(bf_if.valid_o), 64'(1));
    chk({name, "_a_o"}, 64'(bf_if.a_o), 64'(ea));
    chk({name, "_b_o"}, 64'(bf_if.b_o), 64'(eb));
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int nvalid;
    rst_n = 1'b0;
    drive(1'b0, 24'd0, 24'd0, 23'd0, 1'b0, 1'b0);
    #1;
    chk("init_valid_o", 64'(bf_if.valid_o), 64'(0));
    chk("init_a_o", 64'(bf_if.a_o), 64'(0));
    chk("init_b_o", 64'(bf_if.b_o), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed vectors
    run_directed("ct_basic",  24'd1, 24'd1, 23'd1, 1'b0, 1'b0, 23'd2, 23'd0);
    run_directed("ct_wrap",   24'd0, 24'd1, 23'd1, 1'b0, 1'b0, 23'd1, 23'd8380416);
    run_directed("ct_wrap2",  24'd0, 24'd8380416, 23'd8380416, 1'b0, 1'b0, 23'd1, 23'd8380416);
    run_directed("ct_tw0",    24'd123, 24'd456, 23'd0, 1'b0, 1'b0, 23'd123, 23'd123);
    run_directed("gs_basic",  24'd5, 24'd3, 23'd2, 1'b0, 1'b1, 23'd8, 23'd4);
    run_directed("gs_neg",    24'd3, 24'd5, 23'd1, 1'b0, 1'b1, 23'd8, 23'd8380415);
    run_directed("red_2q",    24'd8380418, 24'd16760834, 23'd1, 1'b1, 1'b0, 23'd1, 23'd1);
    run_directed("red_max",   24'd16777215, 24'd0, 23'd1, 1'b1, 1'b0, 23'd16381, 23'd16381);

    // Random back-to-back stream with bubbles
    nvalid = 0;
    while (nvalid < 100) begin
      @(negedge clk);
      drive_random(1'b0);
      if (bf_if.valid_i) nvalid++;
    end
    @(negedge clk);
    bf_if.valid_i = 1'b0;
    repeat (LAT + 2) @(negedge clk);

    // Reset with three vectors in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_random(1'b1);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bf_if.valid_i = 1'b0;
    #1;
    chk("async_rst_valid_o", 64'(bf_if.valid_o), 64'(0));
    chk("async_rst_a_o", 64'(bf_if.a_o), 64'(0));
    chk("async_rst_b_o", 64'(bf_if.b_o), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_directed("post_rst", 24'd10, 24'd20, 23'd3, 1'b0, 1'b0, 23'd70, 23'd8380367);

    repeat (LAT + 2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
